// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/write-data/response bundle between a cache client, the arbiter and the memory port
interface mem_arbiter_if #(
    parameter int ADDR_BITS     = 26,
    parameter int MEM_DATA_BITS = 128,
    parameter int BEATS         = 4
);
    localparam int OFF_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                       req_val;
    logic                       req_rdy;
    logic [ADDR_BITS-1:0]       req_addr;
    logic                       req_rw;
    logic                       req_data_valid;
    logic                       req_data_ready;
    logic [MEM_DATA_BITS-1:0]   req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] req_data_mask;
    logic [OFF_BITS-1:0]        req_data_offset;
    logic                       resp_val;
    logic                       resp_nack;
    logic [MEM_DATA_BITS-1:0]   resp_data;

    // master issues requests and write beats, slave accepts them and returns responses
    modport master (
        output req_val, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask, req_data_offset,
        input  req_rdy, req_data_ready, resp_val, resp_nack, resp_data
    );
    modport slave (
        input  req_val, req_addr, req_rw, req_data_valid, req_data_bits, req_data_mask, req_data_offset,
        output req_rdy, req_data_ready, resp_val, resp_nack, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of icache (c0) and dcache (c1) onto one memory port with in-order read-owner routing
module mem_arbiter #(
    parameter int ADDR_BITS     = 26,
    parameter int MEM_DATA_BITS = 128,
    parameter int BEATS         = 4,
    parameter int OUTSTANDING   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  c0,
    mem_arbiter_if.slave  c1,
    mem_arbiter_if.master mem
);
    localparam int OFF_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_BITS = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [OFF_BITS-1:0] LAST_BEAT  = OFF_BITS'(BEATS - 1);
    localparam logic [OFF_BITS-1:0] BEAT_ONE   = 1;
    localparam logic [PTR_BITS-1:0] PTR_ONE    = 1;
    localparam logic [PTR_BITS:0]   CNT_ONE    = 1;
    localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS + 1)'(OUTSTANDING);

    typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

    state_t               state;
    logic                 grant;
    logic                 rr_prio;
    logic                 lat_rw;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [OFF_BITS-1:0]  wbeat;
    logic [OFF_BITS-1:0]  rbeat;

    logic [OUTSTANDING-1:0] owner;
    logic [PTR_BITS-1:0]    wr_ptr;
    logic [PTR_BITS-1:0]    rd_ptr;
    logic [PTR_BITS:0]      count;

    logic fifo_full, fifo_empty;
    logic elig0, elig1, pick_c1;
    logic mem_accept, push, pop, resp_hit, head, wr_hs;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);

    // a read may only be granted while the owner FIFO has room for it
    assign elig0   = c0.req_val && (c0.req_rw || !fifo_full);
    assign elig1   = c1.req_val && (c1.req_rw || !fifo_full);
    assign pick_c1 = elig1 && (!elig0 || rr_prio);

    assign mem_accept = (state == REQ) && mem.req_rdy;
    assign push       = mem_accept && !lat_rw;
    assign resp_hit   = mem.resp_val && !fifo_empty;
    assign head       = owner[rd_ptr];
    assign pop        = resp_hit && (mem.resp_nack || rbeat == LAST_BEAT);
    assign wr_hs      = (state == WDATA) && mem.req_data_valid && mem.req_data_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            rr_prio  <= 1'b0;
            lat_rw   <= 1'b0;
            lat_addr <= '0;
            wbeat    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        grant    <= pick_c1;
                        lat_addr <= pick_c1 ? c1.req_addr : c0.req_addr;
                        lat_rw   <= pick_c1 ? c1.req_rw : c0.req_rw;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem.req_rdy) begin
                        rr_prio <= ~grant;
                        wbeat   <= '0;
                        state   <= lat_rw ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (wr_hs) begin
                        if (wbeat == LAST_BEAT) begin
                            wbeat <= '0;
                            state <= IDLE;
                        end else begin
                            wbeat <= wbeat + BEAT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // read-owner FIFO and response beat counter run independently of the request FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rbeat  <= '0;
        end else begin
            if (push) begin
                owner[wr_ptr] <= grant;
                wr_ptr        <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (resp_hit) begin
                rbeat <= pop ? '0 : rbeat + BEAT_ONE;
            end
        end
    end

    assign mem.req_val         = (state == REQ);
    assign mem.req_addr        = lat_addr;
    assign mem.req_rw          = lat_rw;
    assign mem.req_data_valid  = (state == WDATA) && (grant ? c1.req_data_valid : c0.req_data_valid);
    assign mem.req_data_bits   = grant ? c1.req_data_bits : c0.req_data_bits;
    assign mem.req_data_mask   = grant ? c1.req_data_mask : c0.req_data_mask;
    assign mem.req_data_offset = wbeat;

    assign c0.req_rdy        = mem_accept && !grant;
    assign c1.req_rdy        = mem_accept && grant;
    assign c0.req_data_ready = (state == WDATA) && !grant && mem.req_data_ready;
    assign c1.req_data_ready = (state == WDATA) && grant && mem.req_data_ready;

    assign c0.resp_val  = resp_hit && !head;
    assign c1.resp_val  = resp_hit && head;
    assign c0.resp_nack = resp_hit && !head && mem.resp_nack;
    assign c1.resp_nack = resp_hit && head && mem.resp_nack;
    assign c0.resp_data = mem.resp_data;
    assign c1.resp_data = mem.resp_data;

    // a response beat with no recorded owner is dropped; flag it in simulation
    resp_has_owner: assert property (@(posedge clk) disable iff (!reset) !(mem.resp_val && fifo_empty));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, directed corner sequences and randomized traffic against an in-bench model of mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if c0_if ();
    mem_arbiter_if c1_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .c0    (c0_if),
        .c1    (c1_if),
        .mem   (mem_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] resp_word(input logic [25:0] a, input int b);
        return {a, 6'(b), 32'hC0DE_0000, 32'(a) ^ 32'h5A5A_5A5A, 32'(b) + 32'h1000};
    endfunction

    function automatic logic [127:0] wdata(input logic [25:0] a, input int b);
        return {32'(b), 32'hBEEF_0000, 6'(b), ~a, 32'(a)};
    endfunction

    function automatic logic [15:0] wmask(input logic [25:0] a, input int b);
        return a[15:0] ^ {4{4'(b + 1)}};
    endfunction

    function automatic bit nack_rule(input logic [25:0] a);
        return a[2:0] == 3'b111;
    endfunction

    task automatic idle_inputs();
        c0_if.req_val = 0; c0_if.req_addr = '0; c0_if.req_rw = 0; c0_if.req_data_valid = 0;
        c0_if.req_data_bits = '0; c0_if.req_data_mask = '0; c0_if.req_data_offset = '0;
        c1_if.req_val = 0; c1_if.req_addr = '0; c1_if.req_rw = 0; c1_if.req_data_valid = 0;
        c1_if.req_data_bits = '0; c1_if.req_data_mask = '0; c1_if.req_data_offset = '0;
        mem_if.req_rdy = 0; mem_if.req_data_ready = 0;
        mem_if.resp_val = 0; mem_if.resp_nack = 0; mem_if.resp_data = '0;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // presents one request, holds it until the arbiter accepts it, checks the forwarded address/rw
    task automatic issue(input bit cl, input logic [25:0] a, input logic rw, output bit ok);
        drive_edge();
        if (cl) begin c1_if.req_val = 1; c1_if.req_addr = a; c1_if.req_rw = rw; end
        else    begin c0_if.req_val = 1; c0_if.req_addr = a; c0_if.req_rw = rw; end
        mem_if.req_rdy = 1;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (cl ? c1_if.req_rdy : c0_if.req_rdy) begin
                ok = 1;
                check("issue_addr", mem_if.req_addr, a);
                check("issue_rw", mem_if.req_rw, rw);
            end
        end
        drive_edge();
        c0_if.req_val = 0; c1_if.req_val = 0; mem_if.req_rdy = 0;
    endtask

    task automatic respond(input bit owner, input logic [25:0] a);
        for (int b = 0; b < 4; b++) begin
            mem_if.resp_val = 1; mem_if.resp_nack = 0; mem_if.resp_data = resp_word(a, b);
            @(negedge clk);
            check("resp_route", {c1_if.resp_val, c0_if.resp_val}, owner ? 2'b10 : 2'b01);
            check("resp_data", owner ? c1_if.resp_data : c0_if.resp_data, resp_word(a, b));
            drive_edge();
        end
        mem_if.resp_val = 0;
    endtask

    typedef struct {
        logic       v0;
        logic       rw0;
        logic [25:0] a0;
        logic       v1;
        logic       rw1;
        logic [25:0] a1;
        logic       gnt;
    } vec_t;

    task automatic run_row(input int idx, input vec_t v);
        logic [25:0] ea;
        logic erw;
        bit seen;
        int wb;
        drive_edge();
        c0_if.req_val = v.v0; c0_if.req_rw = v.rw0; c0_if.req_addr = v.a0;
        c1_if.req_val = v.v1; c1_if.req_rw = v.rw1; c1_if.req_addr = v.a1;
        mem_if.req_rdy = 0;
        ea  = v.gnt ? v.a1 : v.a0;
        erw = v.gnt ? v.rw1 : v.rw0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_if.req_val) seen = 1;
        end
        check($sformatf("row%0d_req_seen", idx), seen, 1);
        check($sformatf("row%0d_addr", idx), mem_if.req_addr, ea);
        check($sformatf("row%0d_rw", idx), mem_if.req_rw, erw);
        check($sformatf("row%0d_rdy_stall", idx), {c1_if.req_rdy, c0_if.req_rdy}, 2'b00);
        drive_edge();
        mem_if.req_rdy = 1;
        @(negedge clk);
        check($sformatf("row%0d_grant", idx), {c1_if.req_rdy, c0_if.req_rdy}, v.gnt ? 2'b10 : 2'b01);
        drive_edge();
        c0_if.req_val = 0; c1_if.req_val = 0; mem_if.req_rdy = 0;
        if (!erw) begin
            respond(v.gnt, ea);
            @(negedge clk);
            check($sformatf("row%0d_resp_done", idx), {c1_if.resp_val, c0_if.resp_val}, 2'b00);
            drive_edge();
        end else begin
            wb = 0;
            for (int cyc = 0; cyc < 40 && wb < 4; cyc++) begin
                if (v.gnt) begin
                    c1_if.req_data_valid = 1; c1_if.req_data_bits = wdata(ea, wb); c1_if.req_data_mask = wmask(ea, wb);
                end else begin
                    c0_if.req_data_valid = 1; c0_if.req_data_bits = wdata(ea, wb); c0_if.req_data_mask = wmask(ea, wb);
                end
                mem_if.req_data_ready = cyc[0];
                @(negedge clk);
                check("row_wvalid", mem_if.req_data_valid, 1);
                check("row_wready_gnt", v.gnt ? c1_if.req_data_ready : c0_if.req_data_ready, mem_if.req_data_ready);
                check("row_wready_other", v.gnt ? c0_if.req_data_ready : c1_if.req_data_ready, 0);
                if (mem_if.req_data_valid && mem_if.req_data_ready) begin
                    check("row_offset", mem_if.req_data_offset, wb);
                    check("row_wdata", mem_if.req_data_bits, wdata(ea, wb));
                    check("row_wmask", mem_if.req_data_mask, wmask(ea, wb));
                    wb++;
                end
                drive_edge();
            end
            check($sformatf("row%0d_wbeats", idx), wb, 4);
            c0_if.req_data_valid = 0; c1_if.req_data_valid = 0; mem_if.req_data_ready = 0;
        end
    endtask

    typedef struct {
        logic [25:0] addr;
        logic        rw;
    } txn_t;

    task automatic random_traffic();
        txn_t        cq0[$];
        txn_t        cq1[$];
        txn_t        t;
        logic [25:0] rq_addr[$];
        bit          rq_own[$];
        bit          pres[2];
        bit          wph[2];
        int          wcnt[2];
        logic [25:0] waddr[2];
        int          mbeat;
        int          mwbeat;
        logic [25:0] mwaddr;
        int          budget;
        bit          r0, r1, own;
        for (int i = 0; i < 25; i++) begin
            t.addr = 26'($urandom); t.rw = ($urandom_range(3) == 0); cq0.push_back(t);
            t.addr = 26'($urandom); t.rw = ($urandom_range(3) == 0); cq1.push_back(t);
        end
        pres = '{0, 0}; wph = '{0, 0}; wcnt = '{0, 0}; waddr = '{26'h0, 26'h0};
        mbeat = 0; mwbeat = 0; mwaddr = '0; budget = 0;
        drive_edge();
        while ((cq0.size() != 0 || cq1.size() != 0 || rq_addr.size() != 0 || wph[0] || wph[1]) && budget < 6000) begin
            if (!pres[0] && !wph[0] && cq0.size() != 0 && $urandom_range(9) < 7) pres[0] = 1;
            if (!pres[1] && !wph[1] && cq1.size() != 0 && $urandom_range(9) < 7) pres[1] = 1;
            c0_if.req_val = pres[0];
            if (pres[0]) begin c0_if.req_addr = cq0[0].addr; c0_if.req_rw = cq0[0].rw; end
            c1_if.req_val = pres[1];
            if (pres[1]) begin c1_if.req_addr = cq1[0].addr; c1_if.req_rw = cq1[0].rw; end
            c0_if.req_data_valid = wph[0] && ($urandom_range(1) == 1);
            c0_if.req_data_bits  = wdata(waddr[0], wcnt[0]);
            c0_if.req_data_mask  = wmask(waddr[0], wcnt[0]);
            c1_if.req_data_valid = wph[1] && ($urandom_range(1) == 1);
            c1_if.req_data_bits  = wdata(waddr[1], wcnt[1]);
            c1_if.req_data_mask  = wmask(waddr[1], wcnt[1]);
            mem_if.req_rdy        = ($urandom_range(1) == 1);
            mem_if.req_data_ready = ($urandom_range(1) == 1);
            if (rq_addr.size() != 0 && $urandom_range(9) < 6) begin
                mem_if.resp_val  = 1;
                mem_if.resp_nack = nack_rule(rq_addr[0]) && (mbeat == 0);
                mem_if.resp_data = resp_word(rq_addr[0], mbeat);
            end else begin
                mem_if.resp_val  = 0;
                mem_if.resp_nack = ($urandom_range(1) == 1);
            end

            @(negedge clk);
            // responses first: a last beat and a new read acceptance may share a cycle
            if (mem_if.resp_val) begin
                own = rq_own[0];
                check("rnd_resp_route", {c1_if.resp_val, c0_if.resp_val}, own ? 2'b10 : 2'b01);
                check("rnd_resp_nack", own ? c1_if.resp_nack : c0_if.resp_nack, mem_if.resp_nack);
                check("rnd_resp_data", own ? c1_if.resp_data : c0_if.resp_data, resp_word(rq_addr[0], mbeat));
                if (mem_if.resp_nack || mbeat == 3) begin
                    void'(rq_addr.pop_front()); void'(rq_own.pop_front()); mbeat = 0;
                end else begin
                    mbeat++;
                end
            end else begin
                check("rnd_resp_quiet", {c1_if.resp_val, c0_if.resp_val}, 2'b00);
            end

            r0 = c0_if.req_rdy; r1 = c1_if.req_rdy;
            check("rnd_rdy_excl", r0 & r1, 0);
            check("rnd_rdy_hs", r0 | r1, mem_if.req_val & mem_if.req_rdy);
            if (r0) begin
                check("rnd_c0_presented", pres[0], 1);
                if (pres[0]) begin
                    check("rnd_c0_addr", mem_if.req_addr, cq0[0].addr);
                    check("rnd_c0_rw", mem_if.req_rw, cq0[0].rw);
                    if (!cq0[0].rw) begin
                        check("rnd_outstanding", rq_addr.size() < 4, 1);
                        rq_addr.push_back(cq0[0].addr); rq_own.push_back(0);
                    end else begin
                        wph[0] = 1; wcnt[0] = 0; waddr[0] = cq0[0].addr; mwbeat = 0; mwaddr = cq0[0].addr;
                    end
                    void'(cq0.pop_front()); pres[0] = 0;
                end
            end
            if (r1) begin
                check("rnd_c1_presented", pres[1], 1);
                if (pres[1]) begin
                    check("rnd_c1_addr", mem_if.req_addr, cq1[0].addr);
                    check("rnd_c1_rw", mem_if.req_rw, cq1[0].rw);
                    if (!cq1[0].rw) begin
                        check("rnd_outstanding", rq_addr.size() < 4, 1);
                        rq_addr.push_back(cq1[0].addr); rq_own.push_back(1);
                    end else begin
                        wph[1] = 1; wcnt[1] = 0; waddr[1] = cq1[0].addr; mwbeat = 0; mwaddr = cq1[0].addr;
                    end
                    void'(cq1.pop_front()); pres[1] = 0;
                end
            end

            if (!wph[0]) check("rnd_c0_wready_idle", c0_if.req_data_ready, 0);
            if (!wph[1]) check("rnd_c1_wready_idle", c1_if.req_data_ready, 0);
            if (mem_if.req_data_valid && mem_if.req_data_ready) begin
                check("rnd_w_owner", wph[0] | wph[1], 1);
                check("rnd_w_offset", mem_if.req_data_offset, mwbeat);
                check("rnd_w_data", mem_if.req_data_bits, wdata(mwaddr, mwbeat));
                check("rnd_w_mask", mem_if.req_data_mask, wmask(mwaddr, mwbeat));
                for (int cl = 0; cl < 2; cl++) begin
                    if (wph[cl]) begin
                        check("rnd_w_ready", cl == 1 ? c1_if.req_data_ready : c0_if.req_data_ready, 1);
                        wcnt[cl]++;
                        if (wcnt[cl] == 4) wph[cl] = 0;
                    end
                end
                mwbeat++;
            end
            drive_edge();
            budget++;
        end
        check("rnd_drained", budget < 6000, 1);
        idle_inputs();
    endtask

    vec_t vt[9];
    bit   ok;
    bit   blocked_seen;

    initial begin
        vt[0] = '{1'b1, 1'b0, 26'h10, 1'b0, 1'b0, 26'h0,  1'b0};
        vt[1] = '{1'b1, 1'b0, 26'h20, 1'b1, 1'b0, 26'h21, 1'b1};
        vt[2] = '{1'b1, 1'b0, 26'h30, 1'b1, 1'b0, 26'h31, 1'b0};
        vt[3] = '{1'b1, 1'b0, 26'h40, 1'b1, 1'b0, 26'h41, 1'b1};
        vt[4] = '{1'b0, 1'b0, 26'h0,  1'b1, 1'b1, 26'hA0, 1'b1};
        vt[5] = '{1'b1, 1'b1, 26'hB0, 1'b1, 1'b1, 26'hB1, 1'b0};
        vt[6] = '{1'b1, 1'b0, 26'h50, 1'b0, 1'b0, 26'h0,  1'b0};
        vt[7] = '{1'b1, 1'b1, 26'hC0, 1'b1, 1'b0, 26'hC1, 1'b1};
        vt[8] = '{1'b1, 1'b0, 26'hD0, 1'b1, 1'b1, 26'hD1, 1'b0};

        idle_inputs();
        reset = 0;
        c0_if.req_val = 1; mem_if.req_rdy = 1; mem_if.req_data_ready = 1; c1_if.req_data_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_if.req_val, mem_if.req_data_valid, c0_if.req_rdy, c1_if.req_rdy,
                                c0_if.req_data_ready, c1_if.req_data_ready, c0_if.resp_val, c1_if.resp_val}, 8'h00);
        check("reset_addr", mem_if.req_addr, 26'h0);
        drive_edge();
        idle_inputs();
        reset = 1;

        for (int i = 0; i < 9; i++) run_row(i, vt[i]);

        // owner FIFO full: a fifth read waits until the first read completes
        for (int i = 0; i < 4; i++) begin
            issue(0, 26'h100 + 26'(i), 0, ok);
            check("t4_issue", ok, 1);
        end
        c0_if.req_val = 1; c0_if.req_addr = 26'h104; c0_if.req_rw = 0; mem_if.req_rdy = 1;
        blocked_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_if.req_val) blocked_seen = 1;
            drive_edge();
        end
        check("t4_full_block", blocked_seen, 0);
        respond(0, 26'h100);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (c0_if.req_rdy) begin
                ok = 1;
                check("t4_fifth_addr", mem_if.req_addr, 26'h104);
            end
            drive_edge();
        end
        check("t4_fifth_issue", ok, 1);
        c0_if.req_val = 0; mem_if.req_rdy = 0;
        for (int i = 1; i < 5; i++) respond(0, 26'h100 + 26'(i));

        // nack on c1's read pops its entry; the next beat belongs to c0
        issue(1, 26'h200, 0, ok); check("t5_issue_c1", ok, 1);
        issue(0, 26'h300, 0, ok); check("t5_issue_c0", ok, 1);
        mem_if.resp_val = 1; mem_if.resp_nack = 1; mem_if.resp_data = resp_word(26'h200, 0);
        @(negedge clk);
        check("t5_nack_route", {c1_if.resp_val, c1_if.resp_nack, c0_if.resp_val, c0_if.resp_nack}, 4'b1100);
        drive_edge();
        mem_if.resp_val = 0; mem_if.resp_nack = 0;
        @(negedge clk);
        check("t5_nack_pulse", {c1_if.resp_val, c1_if.resp_nack}, 2'b00);
        drive_edge();
        respond(0, 26'h300);

        // async reset in the middle of a write burst, with a c1 read still outstanding
        issue(1, 26'h3C0, 0, ok); check("t6_issue_rd", ok, 1);
        issue(1, 26'h3D0, 1, ok); check("t6_issue_wr", ok, 1);
        c1_if.req_data_valid = 1; c1_if.req_data_bits = wdata(26'h3D0, 0); c1_if.req_data_mask = wmask(26'h3D0, 0);
        mem_if.req_data_ready = 1;
        @(negedge clk);
        check("t6_wvalid", mem_if.req_data_valid, 1);
        drive_edge();
        c1_if.req_data_bits = wdata(26'h3D0, 1);
        c0_if.req_val = 1; c0_if.req_addr = 26'h3E0; mem_if.req_rdy = 1;
        reset = 0;
        #1;
        check("t6_rst_immediate", {mem_if.req_val, mem_if.req_data_valid, c0_if.req_rdy, c1_if.req_rdy,
                                   c0_if.req_data_ready, c1_if.req_data_ready, c0_if.resp_val, c1_if.resp_val}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_rst_held", {mem_if.req_val, mem_if.req_data_valid, c0_if.req_rdy, c1_if.req_data_ready}, 4'h0);
        drive_edge();
        idle_inputs();
        reset = 1;
        issue(0, 26'h3E0, 0, ok); check("t6_post_issue", ok, 1);
        respond(0, 26'h3E0);
        @(negedge clk);
        check("t6_post_quiet", {c1_if.resp_val, c0_if.resp_val}, 2'b00);

        random_traffic();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
